cc_event_handshake: RTL and testbench



---
 rtl/cc_event_handshake.sv | 116 +++++++++++
 tb/tb_cc_event_handshake.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cc_event_handshake.sv
// cc_event_handshake
// Moves single-cycle event pulses across a toggle handshake:
//   request toggle -> request synchronizer -> destination edge detect ->
//   acknowledge toggle -> acknowledge synchronizer back to the source.
// Both sides currently run on one clock. The handshake structure is kept
// intact so the path can later become a real clock-domain crossing
// without any change to the ports.
//
// Optional build macro: CC_EVENT_PENDING_EN
//   defined   -> a one-deep pending flag holds one event that arrives while busy
//   undefined -> events that arrive while busy are dropped
//
// busy and out are plain XORs of registers, so they are glitch-free and
// have no combinational path from the event input.

module cc_event_handshake #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic busy,
  output logic out
);

  if ((SYNC_STAGES < 32'd2) || (SYNC_STAGES > 32'd4)) begin : g_bad_sync_stages
    $error("cc_event_handshake: SYNC_STAGES must be in 2..4");
  end

  logic                   req_q;
  logic                   req_d;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   ack_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   accept_s;
  logic                   req_last_s;
  logic                   ack_last_s;

  assign req_last_s = req_sync_q[SYNC_STAGES-1];
  assign ack_last_s = ack_sync_q[SYNC_STAGES-1];

  // The source sees the handshake in flight until the ack toggle returns.
  assign busy = req_q ^ ack_last_s;

  // The destination sees a new event while the synced request differs from its ack.
  assign out  = req_last_s ^ ack_q;

`ifdef CC_EVENT_PENDING_EN
  logic pending_q;
  logic pending_d;

  // Accept from the live input or the stored event; remember one event seen while busy
  always_comb begin
    accept_s  = 1'b0;
    pending_d = pending_q;
    if (!busy) begin
      // A live event and a pending event at the same edge merge into one accept.
      accept_s  = in | pending_q;
      pending_d = 1'b0;
    end else begin
      accept_s = 1'b0;
      if (in) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // Pending event storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  // Accept only while idle; every idle cycle with in high is its own event
  always_comb begin
    accept_s = 1'b0;
    if (!busy && in) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end
`endif

  // Flip the request toggle once per accepted event
  always_comb begin
    req_d = req_q;
    if (accept_s) begin
      req_d = ~req_q;
    end else begin
      req_d = req_q;
    end
  end

  // Handshake registers: request toggle, both synchronizer chains, ack toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      req_sync_q <= {SYNC_STAGES{1'b0}};
      ack_q      <= 1'b0;
      ack_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      req_q      <= req_d;
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
      // The ack copies the synced request, which closes the out pulse after one cycle.
      ack_q      <= req_last_s;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
    end
  end

endmodule

// File: tb/tb_cc_event_handshake.sv
// Testbench for cc_event_handshake (SYNC_STAGES = 2).
// The reference model tracks each accepted event by its age in cycles:
// busy while age is 0..2S, out when age equals S.

module tb_cc_event_handshake;

  localparam int S = 2;
`ifdef CC_EVENT_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic in;
  logic busy;
  logic out;

  int checks;
  int fails;
  int pulses;

  // Behavioural model state
  logic m_inflight;
  int   m_age;
  logic m_pend;
  int   m_acc;
  logic m_busy;
  logic m_out;

  cc_event_handshake #(.SYNC_STAGES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .busy (busy),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_busy = m_inflight;
  assign m_out  = m_inflight && (m_age == S);

  // Reference model: one event in flight, aged once per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_age      <= 0;
      m_pend     <= 1'b0;
    end else begin
      if (!m_busy && (in || m_pend)) begin
        m_inflight <= 1'b1;
        m_age      <= 0;
        m_pend     <= 1'b0;
        m_acc      <= m_acc + 1;
      end else begin
        if (m_inflight) begin
          if (m_age == 2 * S) m_inflight <= 1'b0;
          else m_age <= m_age + 1;
        end
        if (PEND && m_busy && in) m_pend <= 1'b1;
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Compare DUT against the model once per cycle, just after the active edge
  task automatic compare_cycle();
    check_bit("busy_vs_model", busy, m_busy);
    check_bit("out_vs_model", out, m_out);
    if (out === 1'b1) pulses++;
  endtask

  // Drive one input value for the next edge, then sample
  task automatic tick(input logic v);
    @(negedge clk);
    #2 in = v;
    @(posedge clk);
    #1 compare_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  int p0;
  int a0;
  logic [7:0] lit_busy;
  logic [7:0] lit_out;

  initial begin
    checks = 0;
    fails  = 0;
    pulses = 0;
    m_acc  = 0;
    in     = 1'b0;
    rst_n  = 1'b0;

    // Reset held for three cycles with in toggling
    for (int i = 0; i < 3; i++) begin
      tick(i[0] ? 1'b0 : 1'b1);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_out", out, 1'b0);
    end
    @(negedge clk);
    #2 in = 1'b0;
    rst_n = 1'b1;
    p0 = pulses;
    idle(6);
    check_int("post_reset_pulses", pulses - p0, 0);

    // Single event: literal busy/out per cycle after E0 (bit n = cycle after En)
    lit_busy = 8'b0001_1111;
    lit_out  = 8'b0000_0100;
    p0 = pulses;
    a0 = m_acc;
    tick(1'b1);
    check_bit("single_busy_lit", busy, lit_busy[0]);
    check_bit("single_out_lit", out, lit_out[0]);
    for (int n = 1; n < 8; n++) begin
      tick(1'b0);
      check_bit("single_busy_lit", busy, lit_busy[n]);
      check_bit("single_out_lit", out, lit_out[n]);
    end
    check_int("single_pulses", pulses - p0, 1);
    check_int("single_model_accepts", m_acc - a0, 1);

    // Back-to-back: in held high for ten cycles
    p0 = pulses;
    a0 = m_acc;
    for (int i = 0; i < 10; i++) tick(1'b1);
    idle(10);
    check_int("b2b_pulses", pulses - p0, PEND ? 3 : 2);
    check_int("b2b_model_accepts", m_acc - a0, PEND ? 3 : 2);

    // Events at E0 and E3
    p0 = pulses;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    idle(12);
    check_int("drop_pulses", pulses - p0, PEND ? 2 : 1);
    check_bit("drop_busy_idle", busy, 1'b0);

    // Events at E0, E2 and E3
    p0 = pulses;
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    idle(12);
    check_int("pend_pulses", pulses - p0, PEND ? 2 : 1);

    // Reset mid-flight: accept at E0, reset across E2
    p0 = pulses;
    tick(1'b1);
    tick(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_out", out, 1'b0);
    tick(1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(8);
    check_int("midreset_pulses", pulses - p0, 0);
    check_bit("midreset_busy_after", busy, 1'b0);
    tick(1'b1);
    check_bit("after_reset_busy", busy, 1'b1);
    idle(8);
    check_int("after_reset_pulses", pulses - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
